// File: rtl/uart_link_core.sv
`default_nettype none
// ============================================================================
// Module      : uart_link_core
// Description : Full-duplex UART link core. The transmitter is fed by a small
//               TX FIFO. The receiver oversamples the line and detects parity,
//               framing, break and overrun conditions.
// Ports       : clk, rst (async active-low)      - clock / reset
//               baud_div, parity_mode, two_stop  - run-time line settings
//               tx_data/tx_valid/tx_ready        - TX FIFO push interface
//               tx, tx_busy                      - serial out, activity flag
//               rx                               - serial in (asynchronous)
//               rx_data/rx_valid/rx_ready        - received character handshake
//               rx_parity_err/rx_frame_err/rx_overrun - status of held char
// Revision    : 1.0 - initial release
// ============================================================================
module uart_link_core #(
    parameter int DATA_WIDTH    = 8,
    parameter int OVERSAMPLE    = 16,
    parameter int TX_FIFO_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [15:0]           baud_div,
    input  logic [1:0]            parity_mode,
    input  logic                  two_stop,
    input  logic [DATA_WIDTH-1:0] tx_data,
    input  logic                  tx_valid,
    output logic                  tx_ready,
    output logic                  tx,
    output logic                  tx_busy,
    input  logic                  rx,
    output logic [DATA_WIDTH-1:0] rx_data,
    output logic                  rx_valid,
    input  logic                  rx_ready,
    output logic                  rx_parity_err,
    output logic                  rx_frame_err,
    output logic                  rx_overrun
);

    localparam int c_AW = $clog2(TX_FIFO_DEPTH);
    localparam int c_TW = $clog2(OVERSAMPLE);
    localparam int c_BW = $clog2(DATA_WIDTH + 1);
    localparam logic [c_TW-1:0] c_TICK_LAST = c_TW'(OVERSAMPLE - 1);
    localparam logic [c_TW-1:0] c_TICK_MID  = c_TW'(OVERSAMPLE / 2 - 1);
    localparam logic [c_BW-1:0] c_BIT_LAST  = c_BW'(DATA_WIDTH - 1);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } state_t;

    // ------------------------------------------------------------------------
    // Oversample tick generator. The >= compare lets a shrinking baud_div
    // recover immediately instead of counting through the 16-bit range.
    // ------------------------------------------------------------------------
    logic [15:0] baud_cnt_q, baud_cnt_d;
    logic        w_tick;

    always_comb begin
        w_tick     = (baud_cnt_q >= baud_div);
        baud_cnt_d = w_tick ? 16'd0 : baud_cnt_q + 16'd1;
    end

    // ------------------------------------------------------------------------
    // TX FIFO: pointers carry one extra wrap bit to tell full from empty.
    // ------------------------------------------------------------------------
    logic [DATA_WIDTH-1:0] fifo_mem [TX_FIFO_DEPTH];
    logic [c_AW:0]         wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic                  w_empty, w_full, w_push, w_pop;
    logic [DATA_WIDTH-1:0] w_head;

    always_comb begin
        w_empty  = (wr_ptr_q == rd_ptr_q);
        w_full   = (wr_ptr_q[c_AW] != rd_ptr_q[c_AW]) &&
                   (wr_ptr_q[c_AW-1:0] == rd_ptr_q[c_AW-1:0]);
        w_push   = tx_valid && !w_full;
        w_head   = fifo_mem[rd_ptr_q[c_AW-1:0]];
        wr_ptr_d = w_push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = w_pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            fifo_mem[wr_ptr_q[c_AW-1:0]] <= tx_data;
        end
    end

    // ------------------------------------------------------------------------
    // TX state machine
    // ------------------------------------------------------------------------
    state_t                tx_state_q, tx_state_d;
    logic [c_TW-1:0]       tx_tick_q, tx_tick_d;
    logic [c_BW-1:0]       tx_bit_q, tx_bit_d;
    logic [DATA_WIDTH-1:0] tx_shift_q, tx_shift_d;
    logic                  tx_par_q, tx_par_d;
    logic                  tx_par_en_q, tx_par_en_d;
    logic                  tx_two_stop_q, tx_two_stop_d;
    logic                  tx_q, tx_d;
    logic                  w_tx_bit_end, w_launch;

    always_comb begin
        tx_state_d    = tx_state_q;
        tx_tick_d     = tx_tick_q;
        tx_bit_d      = tx_bit_q;
        tx_shift_d    = tx_shift_q;
        tx_par_d      = tx_par_q;
        tx_par_en_d   = tx_par_en_q;
        tx_two_stop_d = tx_two_stop_q;
        tx_d          = tx_q;
        w_launch      = 1'b0;
        w_tx_bit_end  = w_tick && (tx_tick_q == c_TICK_LAST);

        if (w_tick && (tx_state_q != ST_IDLE)) begin
            tx_tick_d = w_tx_bit_end ? '0 : tx_tick_q + 1'b1;
        end

        case (tx_state_q)
            ST_IDLE: begin
                tx_d = 1'b1;
                if (w_tick && !w_empty) begin
                    w_launch = 1'b1;
                end
            end
            ST_START: begin
                if (w_tx_bit_end) begin
                    tx_state_d = ST_DATA;
                    tx_bit_d   = '0;
                    tx_d       = tx_shift_q[0];
                end
            end
            ST_DATA: begin
                if (w_tx_bit_end) begin
                    if (tx_bit_q == c_BIT_LAST) begin
                        tx_bit_d = '0;
                        if (tx_par_en_q) begin
                            tx_state_d = ST_PARITY;
                            tx_d       = tx_par_q;
                        end else begin
                            tx_state_d = ST_STOP;
                            tx_d       = 1'b1;
                        end
                    end else begin
                        tx_bit_d   = tx_bit_q + 1'b1;
                        tx_shift_d = tx_shift_q >> 1;
                        tx_d       = tx_shift_q[1];
                    end
                end
            end
            ST_PARITY: begin
                if (w_tx_bit_end) begin
                    tx_state_d = ST_STOP;
                    tx_bit_d   = '0;
                    tx_d       = 1'b1;
                end
            end
            ST_STOP: begin
                if (w_tx_bit_end) begin
                    if (tx_two_stop_q && (tx_bit_q == '0)) begin
                        tx_bit_d = c_BW'(1);
                    end else if (!w_empty) begin
                        // Chain straight into the next start bit: no idle gap.
                        w_launch = 1'b1;
                    end else begin
                        tx_state_d = ST_IDLE;
                        tx_d       = 1'b1;
                    end
                end
            end
            default: begin
                tx_state_d = ST_IDLE;
                tx_d       = 1'b1;
            end
        endcase

        // Frame launch: pop the FIFO head and latch the line settings.
        w_pop = w_launch;
        if (w_launch) begin
            tx_state_d    = ST_START;
            tx_tick_d     = '0;
            tx_shift_d    = w_head;
            tx_par_en_d   = (parity_mode == 2'b01) || (parity_mode == 2'b10);
            tx_par_d      = (^w_head) ^ (parity_mode == 2'b10);
            tx_two_stop_d = two_stop;
            tx_d          = 1'b0;
        end
    end

    // ------------------------------------------------------------------------
    // RX synchroniser and state machine
    // ------------------------------------------------------------------------
    logic                  sync1_q, sync2_q;
    state_t                rx_state_q, rx_state_d;
    logic                  rx_armed_q, rx_armed_d;
    logic [c_TW-1:0]       rx_tick_q, rx_tick_d;
    logic [c_BW-1:0]       rx_bit_q, rx_bit_d;
    logic [DATA_WIDTH-1:0] rx_shift_q, rx_shift_d;
    logic                  rx_acc_q, rx_acc_d;
    logic [1:0]            rx_mode_q, rx_mode_d;
    logic                  w_rx_par_en, w_done, w_done_perr, w_done_ferr;

    always_comb begin
        rx_state_d  = rx_state_q;
        rx_armed_d  = rx_armed_q;
        rx_tick_d   = rx_tick_q;
        rx_bit_d    = rx_bit_q;
        rx_shift_d  = rx_shift_q;
        rx_acc_d    = rx_acc_q;
        rx_mode_d   = rx_mode_q;
        w_done      = 1'b0;
        w_done_perr = 1'b0;
        w_done_ferr = 1'b0;
        w_rx_par_en = (rx_mode_q == 2'b01) || (rx_mode_q == 2'b10);

        if (w_tick && (rx_state_q != ST_IDLE)) begin
            rx_tick_d = (rx_tick_q == c_TICK_LAST) ? '0 : rx_tick_q + 1'b1;
        end

        case (rx_state_q)
            ST_IDLE: begin
                // Only a line seen high can arm the detector, so a held
                // break yields a single frame.
                if (!rx_armed_q) begin
                    rx_armed_d = sync2_q;
                end else if (!sync2_q) begin
                    rx_state_d = ST_START;
                    rx_armed_d = 1'b0;
                    rx_tick_d  = '0;
                    rx_acc_d   = 1'b0;
                    rx_mode_d  = parity_mode;
                end
            end
            ST_START: begin
                if (w_tick && (rx_tick_q == c_TICK_MID)) begin
                    rx_tick_d = '0;
                    rx_bit_d  = '0;
                    rx_state_d = sync2_q ? ST_IDLE : ST_DATA;
                end
            end
            ST_DATA: begin
                if (w_tick && (rx_tick_q == c_TICK_LAST)) begin
                    rx_shift_d = {sync2_q, rx_shift_q[DATA_WIDTH-1:1]};
                    rx_acc_d   = rx_acc_q ^ sync2_q;
                    if (rx_bit_q == c_BIT_LAST) begin
                        rx_state_d = w_rx_par_en ? ST_PARITY : ST_STOP;
                    end else begin
                        rx_bit_d = rx_bit_q + 1'b1;
                    end
                end
            end
            ST_PARITY: begin
                if (w_tick && (rx_tick_q == c_TICK_LAST)) begin
                    rx_acc_d   = rx_acc_q ^ sync2_q;
                    rx_state_d = ST_STOP;
                end
            end
            ST_STOP: begin
                if (w_tick && (rx_tick_q == c_TICK_LAST)) begin
                    w_done      = 1'b1;
                    w_done_ferr = !sync2_q;
                    w_done_perr = w_rx_par_en &&
                                  (rx_acc_q != (rx_mode_q == 2'b10));
                    rx_state_d  = ST_IDLE;
                end
            end
            default: begin
                rx_state_d = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // RX holding register. A completion coinciding with an accept loads the
    // new character rather than counting as an overrun.
    // ------------------------------------------------------------------------
    logic [DATA_WIDTH-1:0] rx_data_q, rx_data_d;
    logic                  rx_valid_q, rx_valid_d;
    logic                  rx_perr_q, rx_perr_d;
    logic                  rx_ferr_q, rx_ferr_d;
    logic                  rx_ovr_q, rx_ovr_d;
    logic                  w_accept;

    always_comb begin
        rx_data_d  = rx_data_q;
        rx_valid_d = rx_valid_q;
        rx_perr_d  = rx_perr_q;
        rx_ferr_d  = rx_ferr_q;
        rx_ovr_d   = rx_ovr_q;
        w_accept   = rx_valid_q && rx_ready;

        if (w_done && (!rx_valid_q || w_accept)) begin
            rx_data_d  = rx_shift_q;
            rx_valid_d = 1'b1;
            rx_perr_d  = w_done_perr;
            rx_ferr_d  = w_done_ferr;
            rx_ovr_d   = 1'b0;
        end else if (w_done) begin
            rx_ovr_d = 1'b1;
        end else if (w_accept) begin
            rx_valid_d = 1'b0;
            rx_perr_d  = 1'b0;
            rx_ferr_d  = 1'b0;
            rx_ovr_d   = 1'b0;
        end
    end

    // ------------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            baud_cnt_q    <= '0;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            tx_state_q    <= ST_IDLE;
            tx_tick_q     <= '0;
            tx_bit_q      <= '0;
            tx_shift_q    <= '0;
            tx_par_q      <= 1'b0;
            tx_par_en_q   <= 1'b0;
            tx_two_stop_q <= 1'b0;
            tx_q          <= 1'b1;
            sync1_q       <= 1'b1;
            sync2_q       <= 1'b1;
            rx_state_q    <= ST_IDLE;
            rx_armed_q    <= 1'b0;
            rx_tick_q     <= '0;
            rx_bit_q      <= '0;
            rx_shift_q    <= '0;
            rx_acc_q      <= 1'b0;
            rx_mode_q     <= 2'b00;
            rx_data_q     <= '0;
            rx_valid_q    <= 1'b0;
            rx_perr_q     <= 1'b0;
            rx_ferr_q     <= 1'b0;
            rx_ovr_q      <= 1'b0;
        end else begin
            baud_cnt_q    <= baud_cnt_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            tx_state_q    <= tx_state_d;
            tx_tick_q     <= tx_tick_d;
            tx_bit_q      <= tx_bit_d;
            tx_shift_q    <= tx_shift_d;
            tx_par_q      <= tx_par_d;
            tx_par_en_q   <= tx_par_en_d;
            tx_two_stop_q <= tx_two_stop_d;
            tx_q          <= tx_d;
            sync1_q       <= rx;
            sync2_q       <= sync1_q;
            rx_state_q    <= rx_state_d;
            rx_armed_q    <= rx_armed_d;
            rx_tick_q     <= rx_tick_d;
            rx_bit_q      <= rx_bit_d;
            rx_shift_q    <= rx_shift_d;
            rx_acc_q      <= rx_acc_d;
            rx_mode_q     <= rx_mode_d;
            rx_data_q     <= rx_data_d;
            rx_valid_q    <= rx_valid_d;
            rx_perr_q     <= rx_perr_d;
            rx_ferr_q     <= rx_ferr_d;
            rx_ovr_q      <= rx_ovr_d;
        end
    end

    assign tx_ready      = !w_full;
    assign tx            = tx_q;
    assign tx_busy       = (tx_state_q != ST_IDLE) || !w_empty;
    assign rx_data       = rx_data_q;
    assign rx_valid      = rx_valid_q;
    assign rx_parity_err = rx_perr_q;
    assign rx_frame_err  = rx_ferr_q;
    assign rx_overrun    = rx_ovr_q;

endmodule
`default_nettype wire

// File: doc/uart_link_core.md
# uart_link_core

Parametrised full-duplex UART link core: a transmitter with a TX FIFO, and an oversampling receiver with parity, framing, break and overrun detection. It is the synthesizable DUT that sits between the master and slave agent BFMs on the UART interface in the HDL top. Data width, oversampling ratio and FIFO depth are build-time parameters; baud rate, parity mode and stop-bit count are run-time inputs.

## Interface
- DATA_WIDTH, 8: bits per character. Legal range 5–8.
- OVERSAMPLE, 16: ticks per bit. Must be even, minimum 8.
- TX_FIFO_DEPTH, 4: TX FIFO entries. Must be a power of 2, minimum 2.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-low reset.
- baud_div  in  16  clocks per oversample tick, minus 1.
- parity_mode  in  2  00 none, 01 even, 10 odd, 11 none.
- two_stop  in  1  1 selects two TX stop bits.
- tx_data  in  DATA_WIDTH  character to send.
- tx_valid  in  1  push request.
- tx_ready  out  1  FIFO not full.
- tx  out  1  serial line out; idles high.
- tx_busy  out  1  high while a frame is in flight or the FIFO is non-empty.
- rx  in  1  serial line in; asynchronous to clk.
- rx_data  out  DATA_WIDTH  received character.
- rx_valid  out  1  rx_data holds an unread character.
- rx_ready  in  1  consumer accepts rx_data.
- rx_parity_err  out  1  parity error for the held character.
- rx_frame_err  out  1  the first stop bit was sampled as 0.
- rx_overrun  out  1  one or more frames were lost since the last accept.

## Operation
- **Tick generator:** a 16-bit counter runs 0..baud_div and pulses `tick` on wrap. It resets to 0 whenever count ≥ baud_div, so it cannot lock up if baud_div changes. Changing baud_div mid-frame corrupts that frame only.
- **TX FIFO:**
  - Push occurs when tx_valid && tx_ready; tx_ready = !full.
  - A push while full is ignored.
  - Pop occurs on entry to the START state.
- **TX state machine:** IDLE → START → DATA → PARITY → STOP → IDLE or START.
  - Each bit lasts OVERSAMPLE ticks.
  - parity_mode and two_stop are latched at START.
  - Data is sent LSB first.
  - PARITY is skipped when parity is none. The even/odd bit makes the total count of 1s across data and parity even or odd, respectively.
  - STOP is 1 or 2 bit times.
  - After STOP, the FSM goes directly to START if the FIFO is non-empty, so there is no idle gap.
- **RX synchroniser:** 2 flops, both reset to 1.
- **RX state machine:** IDLE → START → DATA → PARITY → STOP → IDLE.
  - IDLE arms only after the synchronised rx has been seen high at least once, so a held break produces exactly one frame.
  - A 1→0 transition in IDLE enters START.
  - At OVERSAMPLE/2 ticks the line is re-sampled. If it is 1, this is a glitch: return to IDLE with no output.
  - Each subsequent bit is sampled at the bit centre, every OVERSAMPLE ticks.
  - parity_mode is latched at start detection.
  - Only the first stop bit is checked.
- **RX holding register:**
  - At the stop-bit sample, if rx_valid = 0: load rx_data, rx_parity_err and rx_frame_err, and set rx_valid.
  - If rx_valid = 1 at the stop-bit sample: the new frame is discarded, the held data is kept, and rx_overrun is set.
  - Accept occurs when rx_valid && rx_ready. Accept clears rx_valid, both error flags and rx_overrun on the next edge.
  - If an accept and a new frame completion land in the same cycle: the new frame is loaded, rx_valid stays 1, and rx_overrun = 0.
- **Break:** all-zero data and stop = 0 → rx_data = 0 and rx_frame_err = 1. Parity is checked normally. The receiver then waits in IDLE for rx to return high.

## Timing
- **Reset values:** tx = 1, tx_ready = 1, tx_busy = 0, rx_valid = 0, rx_data = 0, all error flags = 0. FIFO is empty. Both FSMs are in IDLE and the tick counter is 0.
- **Reset mid-frame:** tx goes to 1 asynchronously. The FIFO contents and the partial RX frame are discarded.
- **Bit time:** OVERSAMPLE × (baud_div + 1) clocks.
- **TX frame length:** 1 + DATA_WIDTH + (parity ? 1 : 0) + (two_stop ? 2 : 1) bits.
- **TX latency:** tx falls at the first tick after the FIFO becomes non-empty while idle, i.e. within baud_div + 2 clocks of the push.
- **tx_ready:** deasserts the cycle after the push that fills the FIFO.
- **rx_valid:** rises 1 clock after the stop-bit centre sample, i.e. 2 synchroniser clocks plus (frame bits − 0.5) bit times after the start edge.

## Test plan
DATA_WIDTH = 8, OVERSAMPLE = 16, baud_div = 1 (32 clk/bit), tx looped back to rx.

- **Plain frame:** push 0xA5, parity none, 1 stop → tx line reads 0,1,0,1,0,0,1,0,1,1 over 320 clocks. rx_valid rises with rx_data = 0xA5 and no error flags.
- **Parity:**
  - Even parity, 0x07 → parity bit 1; rx_parity_err = 0.
  - Odd parity, 0x07 → parity bit 0.
  - Force the parity bit inverted on rx → rx_parity_err = 1 with rx_data = 0x07.
- **FIFO full and back-to-back:** baud_div = 7; push 0x01..0x05 on consecutive clocks from idle.
  - tx_ready = 0 after the 4th push, so 0x05 is dropped.
  - Four frames 0x01..0x04 go out with no idle gap.
  - tx_busy falls after the last stop bit.
- **Break:** drive rx = 0 for 20 bit times, then 1 → exactly one rx_valid with rx_data = 0x00 and rx_frame_err = 1. A later 0x3C frame is received correctly.
- **Overrun:** send 0x11 then 0x22 with rx_ready = 0 → rx_data stays 0x11 and rx_overrun = 1. Pulse rx_ready → all flags clear.
- **Glitch and reset:**
  - rx low for 4 ticks → no rx_valid.
  - Assert rst mid-DATA → tx = 1 immediately, tx_busy = 0, and the FIFO reads empty.
